// File: rtl/reaction_pkg.sv
// Shared state encodings for the multi-player reaction game (FSM and display block).
// Pure constants/helpers, no logic of its own.
package reaction_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WAIT   = 3'd1;
   localparam logic [2:0] ST_READY  = 3'd2;
   localparam logic [2:0] ST_TIMING = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;
   localparam logic [2:0] ST_ERROR  = 3'd5;
   localparam logic [2:0] ST_TMO    = 3'd6;

   // Result states wait for a start press before returning to IDLE.
   function automatic logic is_result_state(input logic [2:0] st);
      return (st == ST_DONE) || (st == ST_ERROR) || (st == ST_TMO);
   endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index priority encoder over the react buttons; purely combinational.
// any flags that at least one request bit is set.
module prio_enc #(
   parameter int NUM_PLAYERS = 4,
   parameter int ID_W        = $clog2(NUM_PLAYERS)
) (
   input  logic [NUM_PLAYERS-1:0] req,
   output logic [ID_W-1:0]        idx,
   output logic                   any
);

   always_comb begin
      idx = '0;
      // Scan downwards so the last match written is the lowest index.
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = ID_W'(i);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/multi_reaction_fsm.sv
// Round controller for an N-player reaction game: start -> random wait -> LED -> first press wins.
// One-cycle state latency; outputs decode registered state, stop_timer is a registered pulse.
module multi_reaction_fsm
   import reaction_pkg::*;
#(
   parameter int NUM_PLAYERS = 4,
   parameter int TIME_W      = 14,
   parameter int TIMEOUT     = 9999
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start_btn,
   input  logic [NUM_PLAYERS-1:0]         react_btn,
   input  logic                           delay_done,
   input  logic [TIME_W-1:0]              elapsed_time,
   output logic                           led,
   output logic                           start_timer,
   output logic                           stop_timer,
   output logic                           done,
   output logic                           timeout,
   output logic                           show_error,
   output logic [NUM_PLAYERS-1:0]         error_mask,
   output logic [$clog2(NUM_PLAYERS)-1:0] winner_id,
   output logic [TIME_W-1:0]              result_time,
   output logic [2:0]                     state_out
);

   localparam int              ID_W      = $clog2(NUM_PLAYERS);
   localparam logic [TIME_W-1:0] TMO_LIMIT = TIME_W'(TIMEOUT);

   logic [2:0]             state_q;
   logic [2:0]             state_d;
   logic                   start_prev_q;
   logic                   start_edge;
   logic [NUM_PLAYERS-1:0] error_mask_q;
   logic [ID_W-1:0]        winner_q;
   logic [TIME_W-1:0]      result_q;
   logic                   stop_q;
   logic [ID_W-1:0]        first_idx;
   logic                   any_react;

   prio_enc #(
      .NUM_PLAYERS (NUM_PLAYERS),
      .ID_W        (ID_W)
   ) u_prio_enc (
      .req (react_btn),
      .idx (first_idx),
      .any (any_react)
   );

   assign start_edge = start_btn & ~start_prev_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_edge) state_d = ST_WAIT;
         // A press during the wait is a false start even if the delay expires together.
         ST_WAIT:   if (any_react) state_d = ST_ERROR;
                    else if (delay_done) state_d = ST_READY;
         ST_READY:  state_d = ST_TIMING;
         ST_TIMING: if (any_react) state_d = ST_DONE;
                    else if (elapsed_time >= TMO_LIMIT) state_d = ST_TMO;
         ST_DONE, ST_ERROR, ST_TMO: if (start_edge) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         start_prev_q <= 1'b0;
         error_mask_q <= '0;
         winner_q     <= '0;
         result_q     <= '0;
         stop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_btn;
         stop_q       <= (state_q == ST_TIMING) && (state_d != ST_TIMING);
         if (state_q == ST_WAIT && any_react) begin
            error_mask_q <= react_btn;
         end
         if (state_q == ST_TIMING && any_react) begin
            winner_q <= first_idx;
            result_q <= elapsed_time;
         end
         if (is_result_state(state_q) && start_edge) begin
            error_mask_q <= '0;
            winner_q     <= '0;
            result_q     <= '0;
         end
      end
   end

   assign led         = (state_q == ST_READY) || (state_q == ST_TIMING);
   assign start_timer = (state_q == ST_READY);
   assign stop_timer  = stop_q;
   assign done        = (state_q == ST_DONE);
   assign timeout     = (state_q == ST_TMO);
   assign show_error  = (state_q == ST_ERROR);
   assign error_mask  = error_mask_q;
   assign winner_id   = winner_q;
   assign result_time = result_q;
   assign state_out   = state_q;

endmodule

// File: tb/tb_multi_reaction_fsm.sv
// Self-checking bench: directed scenarios plus random play against a round-level reference model.
module tb_multi_reaction_fsm;

   localparam int NP = 4;
   localparam int TW = 14;
   localparam int TO = 9999;

   typedef enum int {P_IDLE = 0, P_WAIT = 1, P_READY = 2, P_TIMING = 3,
                     P_DONE = 4, P_ERROR = 5, P_TMO = 6} phase_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start_btn;
   logic [NP-1:0] react_btn;
   logic          delay_done;
   logic [TW-1:0] elapsed_time;
   logic          led, start_timer, stop_timer, done, timeout, show_error;
   logic [NP-1:0] error_mask;
   logic [1:0]    winner_id;
   logic [TW-1:0] result_time;
   logic [2:0]    state_out;

   int n_checks = 0;
   int n_pass   = 0;

   phase_t        m_phase;
   logic [NP-1:0] m_mask;
   int            m_win;
   int            m_rt;
   bit            m_stop;
   bit            m_prev;

   always #5 clk = ~clk;

   multi_reaction_fsm #(.NUM_PLAYERS(NP), .TIME_W(TW), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .start_btn    (start_btn),
      .react_btn    (react_btn),
      .delay_done   (delay_done),
      .elapsed_time (elapsed_time),
      .led          (led),
      .start_timer  (start_timer),
      .stop_timer   (stop_timer),
      .done         (done),
      .timeout      (timeout),
      .show_error   (show_error),
      .error_mask   (error_mask),
      .winner_id    (winner_id),
      .result_time  (result_time),
      .state_out    (state_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic int lowest_player(input logic [NP-1:0] r);
      logic [NP-1:0] iso;
      iso = r & (~r + 1'b1);
      return $clog2(iso);
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE;
      m_mask  = '0;
      m_win   = 0;
      m_rt    = 0;
      m_stop  = 0;
      m_prev  = 0;
   endtask

   task automatic model_step(input bit s, input logic [NP-1:0] r, input bit d, input int e);
      bit pressed_now;
      pressed_now = s && !m_prev;
      m_prev = s;
      m_stop = 0;
      case (m_phase)
         P_IDLE:  if (pressed_now) m_phase = P_WAIT;
         P_WAIT: begin
            if (r != 0) begin
               m_phase = P_ERROR;
               m_mask  = r;
            end else if (d) begin
               m_phase = P_READY;
            end
         end
         P_READY: m_phase = P_TIMING;
         P_TIMING: begin
            if (r != 0) begin
               m_phase = P_DONE;
               m_win   = lowest_player(r);
               m_rt    = e;
               m_stop  = 1;
            end else if (e >= TO) begin
               m_phase = P_TMO;
               m_stop  = 1;
            end
         end
         default: begin
            if (pressed_now) begin
               m_phase = P_IDLE;
               m_mask  = '0;
               m_win   = 0;
               m_rt    = 0;
            end
         end
      endcase
   endtask

   task automatic check_outputs();
      check("state_out",   {29'd0, state_out}, m_phase);
      check("led",         {31'd0, led}, (m_phase == P_READY || m_phase == P_TIMING) ? 1 : 0);
      check("start_timer", {31'd0, start_timer}, (m_phase == P_READY) ? 1 : 0);
      check("stop_timer",  {31'd0, stop_timer}, m_stop ? 1 : 0);
      check("done",        {31'd0, done}, (m_phase == P_DONE) ? 1 : 0);
      check("timeout",     {31'd0, timeout}, (m_phase == P_TMO) ? 1 : 0);
      check("show_error",  {31'd0, show_error}, (m_phase == P_ERROR) ? 1 : 0);
      check("error_mask",  {28'd0, error_mask}, {28'd0, m_mask});
      check("winner_id",   {30'd0, winner_id}, m_win);
      check("result_time", {18'd0, result_time}, m_rt);
   endtask

   task automatic step(input bit s, input logic [NP-1:0] r, input bit d, input int e);
      start_btn    = s;
      react_btn    = r;
      delay_done   = d;
      elapsed_time = TW'(e);
      @(posedge clk);
      model_step(s, r, d, e);
      @(negedge clk);
      check_outputs();
   endtask

   // From IDLE with start released: press, delay expiry, one READY cycle -> TIMING.
   task automatic go_timing();
      step(1, '0, 0, 0);
      step(0, '0, 1, 0);
      step(0, '0, 0, 0);
   endtask

   task automatic ack_to_idle();
      step(0, '0, 0, 0);
      step(1, '0, 0, 0);
      step(0, '0, 0, 0);
   endtask

   initial begin
      bit s_lvl;
      reset        = 1'b1;
      start_btn    = 1'b0;
      react_btn    = '0;
      delay_done   = 1'b0;
      elapsed_time = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs();
      reset = 1'b0;
      step(0, '0, 0, 0);

      // Basic win: player 2 at 250.
      go_timing();
      step(0, 4'b0100, 0, 250);
      check("win_state", {29'd0, state_out}, 4);
      check("win_id",    {30'd0, winner_id}, 2);
      check("win_time",  {18'd0, result_time}, 250);
      check("win_stop",  {31'd0, stop_timer}, 1);
      step(0, '0, 0, 300);
      check("win_stop_once", {31'd0, stop_timer}, 0);

      // Start held across the acknowledge must not start a new round.
      step(1, '0, 0, 0);
      check("held_idle", {29'd0, state_out}, 0);
      repeat (4) step(1, '0, 0, 0);
      check("held_stays", {29'd0, state_out}, 0);
      step(0, '0, 0, 0);
      step(1, '0, 0, 0);
      check("rearm_wait", {29'd0, state_out}, 1);

      // False start beats a simultaneous delay expiry.
      step(0, 4'b1010, 1, 0);
      check("fs_state", {29'd0, state_out}, 5);
      check("fs_mask",  {28'd0, error_mask}, 32'b1010);
      check("fs_err",   {31'd0, show_error}, 1);
      ack_to_idle();
      check("fs_cleared", {28'd0, error_mask}, 0);

      // Two players together: lowest index wins.
      go_timing();
      step(0, 4'b0110, 0, 77);
      check("tie_id", {30'd0, winner_id}, 1);
      ack_to_idle();

      // Timeout boundary.
      go_timing();
      step(0, '0, 0, 9998);
      check("tmo_below", {29'd0, state_out}, 3);
      step(0, '0, 0, 9999);
      check("tmo_state", {29'd0, state_out}, 6);
      check("tmo_flag",  {31'd0, timeout}, 1);
      check("tmo_stop",  {31'd0, stop_timer}, 1);
      step(0, '0, 0, 10000);
      check("tmo_stop_once", {31'd0, stop_timer}, 0);
      ack_to_idle();

      // React at the limit wins over the timeout.
      go_timing();
      step(0, 4'b1000, 0, 9999);
      check("edge_done", {29'd0, state_out}, 4);
      check("edge_id",   {30'd0, winner_id}, 3);
      ack_to_idle();

      // Asynchronous reset mid-round.
      go_timing();
      #2 reset = 1'b1;
      #1;
      check("arst_state", {29'd0, state_out}, 0);
      check("arst_led",   {31'd0, led}, 0);
      model_reset();
      @(negedge clk);
      check_outputs();
      reset = 1'b0;
      step(1, '0, 0, 0);
      check("arst_fresh", {29'd0, state_out}, 1);

      // Random play.
      s_lvl = 0;
      for (int c = 0; c < 3000; c++) begin
         logic [NP-1:0] r;
         int e;
         if ($urandom_range(399) == 0) begin
            reset = 1'b1;
            model_reset();
            @(negedge clk);
            check_outputs();
            reset = 1'b0;
         end
         if ($urandom_range(2) == 0) s_lvl = ~s_lvl;
         r = ($urandom_range(7) == 0) ? NP'($urandom) : '0;
         e = ($urandom_range(3) == 0) ? 9990 + $urandom_range(19) : $urandom_range(9989);
         step(s_lvl, r, ($urandom_range(4) == 0), e);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multi_reaction_fsm.md
MULTI_REACTION_FSM -- requirements
Module: multi_reaction_fsm

Interface
REQ-001 Parameter NUM_PLAYERS, default 4: number of react buttons, range 2..16.
REQ-002 Parameter TIME_W, default 14: width of elapsed_time and result_time.
REQ-003 Parameter TIMEOUT, default 9999: elapsed_time value at or above which a round with no reaction times out.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port start_btn, input, 1: start / acknowledge button, synchronous, level.
REQ-007 Port react_btn, input, NUM_PLAYERS: per-player react buttons, synchronous, level.
REQ-008 Port delay_done, input, 1: random-delay expiry from the delay block.
REQ-009 Port elapsed_time, input, TIME_W: running reaction counter from the timer block.
REQ-010 Port led, output, 1: stimulus LED.
REQ-011 Port start_timer, output, 1: one-cycle timer start pulse.
REQ-012 Port stop_timer, output, 1: one-cycle timer stop pulse.
REQ-013 Port done, output, 1: valid result held.
REQ-014 Port timeout, output, 1: round ended with no reaction.
REQ-015 Port show_error, output, 1: false start occurred.
REQ-016 Port error_mask, output, NUM_PLAYERS: players that pressed during WAIT.
REQ-017 Port winner_id, output, clog2(NUM_PLAYERS): index of the winning player.
REQ-018 Port result_time, output, TIME_W: elapsed_time captured at the win.
REQ-019 Port state_out, output, 3: current state encoding.

Function
REQ-020 States SHALL be IDLE=0, WAIT=1, READY=2, TIMING=3, DONE=4, ERROR=5, TMO=6; code 7 goes to IDLE on the next edge.
REQ-021 start_btn SHALL act only on its rising edge (registered previous value), so a held button never starts two rounds.
REQ-022 IDLE: start edge -> WAIT; react_btn ignored.
REQ-023 WAIT, any react_btn bit high -> ERROR with error_mask <= react_btn in the same edge; this takes priority over a simultaneous delay_done.
REQ-024 WAIT, delay_done with no react -> READY.
REQ-025 READY SHALL last exactly one cycle with led=1 and start_timer=1, then go to TIMING.
REQ-026 TIMING: led=1; any react bit -> DONE, with winner_id <= lowest set index and result_time <= elapsed_time.
REQ-027 TIMING: elapsed_time >= TIMEOUT with no react -> TMO; a react in the same cycle wins over the timeout.
REQ-028 stop_timer SHALL be a registered pulse, high in the first cycle of DONE or TMO only.
REQ-029 done, timeout and show_error SHALL be high throughout DONE, TMO and ERROR respectively.
REQ-030 DONE, ERROR or TMO: start edge -> IDLE, clearing error_mask, winner_id and result_time to 0.
REQ-031 winner_id, result_time and error_mask SHALL hold their values until cleared or reset.
REQ-032 state_out SHALL equal the state register directly, with no extra cycle of lag.
REQ-033 All outputs other than stop_timer SHALL be decoded from registered state and data (no input-to-output combinational path).

Reset
REQ-034 While reset is high, state=IDLE, the start edge register=0, and every output is 0 regardless of clk.
REQ-035 Reset mid-round SHALL abort immediately; the first rising start edge after release starts a fresh round.

Structure
REQ-036 State encodings SHALL be localparams in a shared package, reaction_pkg, also used by the display block.
REQ-037 Lowest-index winner selection SHALL be one sub-module, prio_enc, parametrised by NUM_PLAYERS.

Verification
REQ-038 Reset, start, delay_done, then react_btn=4'b0100 at elapsed_time=250 -> DONE, winner_id=2, result_time=250, one stop_timer pulse.
REQ-039 react_btn=4'b1010 in WAIT together with delay_done -> ERROR, error_mask=4'b1010, show_error=1.
REQ-040 react_btn=4'b0110 in one TIMING cycle -> winner_id=1.
REQ-041 No react and elapsed_time rises to 9999 -> TMO, timeout=1, one stop_timer pulse; react at 9999 instead -> DONE.
REQ-042 start_btn held high across DONE -> IDLE and stays IDLE until start_btn falls and rises again.
REQ-043 reset asserted asynchronously in TIMING -> state_out=0 and led=0 before the next clk edge.
